glb_stream_loader: RTL

//  Receiving end of the DRAM->GLB input stream into Top. After a one-cycle start pulse on ready,

---
 rtl/glb_stream_loader.sv | 105 ++++++++++
 1 files changed

// File: rtl/glb_stream_loader.sv
// DRAM->GLB stream loader: routes ifmap, weight, then bias words to the GLB write ports.
// Optional running checksum on load_cksum is enabled by defining GLB_LOADER_CKSUM_EN.
module glb_stream_loader #(
    parameter int unsigned IFMAP_WORDS  = 16,
    parameter int unsigned WEIGHT_WORDS = 1024,
    parameter int unsigned BIAS_WORDS   = 128,
    parameter int unsigned ADDR_W       = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ready,
    input  logic              i_en,
    input  logic [31:0]       data_in,
    output logic              glb_we_ifmap,
    output logic              glb_we_weight,
    output logic              glb_we_bias,
    output logic [ADDR_W-1:0] glb_waddr,
    output logic [31:0]       glb_wdata,
    output logic              busy,
    output logic              load_done,
    output logic [31:0]       load_cksum
);

    localparam logic [ADDR_W-1:0] IFMAP_LAST  = ADDR_W'(IFMAP_WORDS - 1);
    localparam logic [ADDR_W-1:0] WEIGHT_LAST = ADDR_W'(WEIGHT_WORDS - 1);
    localparam logic [ADDR_W-1:0] BIAS_LAST   = ADDR_W'(BIAS_WORDS - 1);

    typedef enum logic [2:0] {IDLE, IFMAP, WEIGHT, BIAS, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic              accept;
    logic              sec_last;

    always_comb begin
        accept   = 1'b0;
        sec_last = 1'b0;
        unique case (state)
            IFMAP:   begin accept = i_en && !ready; sec_last = (cnt == IFMAP_LAST);  end
            WEIGHT:  begin accept = i_en && !ready; sec_last = (cnt == WEIGHT_LAST); end
            BIAS:    begin accept = i_en && !ready; sec_last = (cnt == BIAS_LAST);   end
            default: begin accept = 1'b0;           sec_last = 1'b0;                 end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            glb_we_ifmap  <= 1'b0;
            glb_we_weight <= 1'b0;
            glb_we_bias   <= 1'b0;
            glb_waddr     <= '0;
            glb_wdata     <= '0;
            busy          <= 1'b0;
            load_done     <= 1'b0;
        end else begin
            glb_we_ifmap  <= 1'b0;
            glb_we_weight <= 1'b0;
            glb_we_bias   <= 1'b0;
            load_done     <= 1'b0;
            if (ready) begin
                // Restart drops any word presented alongside ready.
                state <= IFMAP;
                cnt   <= '0;
                busy  <= 1'b1;
            end else if (accept) begin
                glb_waddr <= cnt;
                glb_wdata <= data_in;
                cnt       <= sec_last ? '0 : cnt + 1'b1;
                unique case (state)
                    IFMAP: begin
                        glb_we_ifmap <= 1'b1;
                        if (sec_last) state <= WEIGHT;
                    end
                    WEIGHT: begin
                        glb_we_weight <= 1'b1;
                        if (sec_last) state <= BIAS;
                    end
                    BIAS: begin
                        glb_we_bias <= 1'b1;
                        if (sec_last) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            load_done <= 1'b1;
                        end
                    end
                    default: state <= state;
                endcase
            end
        end
    end

`ifdef GLB_LOADER_CKSUM_EN
    always_ff @(posedge clk) begin
        if (rst || ready)
            load_cksum <= '0;
        else if (accept)
            load_cksum <= load_cksum + data_in;
    end
`else
    assign load_cksum = '0;
`endif

endmodule
